mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  - Shares one single-ported unified memory between instruction fetch (IF) and load/store (LS) requesters.
//  - Sits between the CPU core and the memory that replaces the split IMEM/DMEM pair.
//  - Sequences each access (grant, issue, wait, respond) with fixed memory latency.
//  - Enforces LS-priority arbitration with a fetch anti-starvation guard.
// PARAMETERS
//  - MEM_LAT     1  cycles from the mem_en cycle to mem_rdata valid (>=1)
//  - MAX_STREAK  4  max consecutive LS grants while IF is pending before IF is forced (>=1)
//  - AW          32 address width
// PORTS
//  - clk        in   1   clock, rising edge
//  - rst        in   1   reset: asynchronous, active-low
//  - halt       in   1   level; blocks new IF grants (LS still served)
//  - if_req     in   1   fetch request; held until if_gnt
//  - if_addr    in   AW  fetch byte address (word access)
//  - if_gnt     out  1   fetch accepted this cycle
//  - if_rvalid  out  1   one-cycle pulse; if_rdata valid
//  - if_rdata   out  32  fetched word
//  - ls_req     in   1   load/store request; held until ls_gnt
//  - ls_we      in   1   1 = store
//  - ls_size    in   2   0 = byte, 1 = half, 2 = word
//  - ls_addr    in   AW  byte address
//  - ls_wdata   in   32  store data
//  - ls_gnt     out  1   LS accepted this cycle
//  - ls_rvalid  out  1   one-cycle pulse; load data valid or store done
//  - ls_rdata   out  32  load data (0 for stores)
//  - mem_en     out  1   one-cycle command strobe
//  - mem_we     out  1   write enable, qualified by mem_en
//  - mem_size   out  2   access size
//  - mem_addr   out  AW  access address
//  - mem_wdata  out  32  write data
//  - mem_rdata  in   32  read data, valid MEM_LAT cycles after the mem_en cycle
//  - idle       out  1   FSM in IDLE, nothing in flight
// BEHAVIOUR
//  - FSM states: IDLE, ISSUE, WAIT, RESP.
//    - IDLE/RESP + grant -> ISSUE.
//    - ISSUE -> WAIT if MEM_LAT>1, else -> RESP.
//    - WAIT counts MEM_LAT-1 cycles -> RESP.
//    - RESP with no grant -> IDLE.
//  - Grant is combinational, only in IDLE or RESP; gnt is a one-hot pulse.
//    - LS wins when both request, unless streak==MAX_STREAK and if_req is high; then IF wins.
//    - IF is never granted while halt=1.
//  - streak counter:
//    - +1 on an LS grant while if_req is high; saturates at MAX_STREAK.
//    - Cleared on any IF grant, or when if_req is low.
//  - Command (we, size, addr, wdata, owner) is registered at the grant edge.
//    - mem_* are driven from these registers; mem_en=1 only in ISSUE.
//  - mem_rdata is captured on the edge ending cycle (ISSUE + MEM_LAT).
//  - rvalid pulses in RESP to the owner only; rdata stays held until the next capture.
//  - Timeline, grant cycle T: mem_en at T+1, mem_rdata at T+1+MEM_LAT, rvalid at T+2+MEM_LAT.
//  - Back-to-back: a grant in RESP gives the next ISSUE at RESP+1.
//  - Misaligned LS (half addr[0]=1; word addr[1:0]!=0) is issued unchanged; checking is the requester's job.
//  - halt asserted mid-fetch: the in-flight fetch completes and if_rvalid still pulses.
//  - Reset (asynchronous): FSM->IDLE, streak=0, counter=0, command registers=0.
//    - All outputs 0 except idle=1.
//    - Reset mid-access drops the access with no rvalid.
// CONFIGURATION
//  - Macro MEM_ARB_STATS_EN.
//    - Defined: adds outputs if_grant_cnt[31:0] and ls_grant_cnt[31:0].
//      Each increments on its gnt pulse, wraps at 2^32, and resets to 0.
//    - Undefined: ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  - Shared package mem_arb_pkg:
//    - FSM state encoding.
//    - Owner encoding (OWN_IF, OWN_LS).
//    - Size codes (SZ_B, SZ_H, SZ_W).
//  - One sub-module, arb_prio_sel: combinational grant select plus the streak register.
//  - FSM, latency counter and command/data registers stay in the top module.
// TESTING
//  - Reset: rst=0 mid-WAIT, then release -> idle=1, no rvalid, next if_req granted the same cycle.
//  - Single fetch, MEM_LAT=1: if_req at T, addr=0x10, mem_rdata=0x00500093.
//    Expect if_gnt@T, mem_en@T+1, if_rvalid@T+3, if_rdata=0x00500093.
//  - Contention: if_req and ls_req both held high continuously, MAX_STREAK=4.
//    Grant order LS,LS,LS,LS,IF,LS...; no IF starvation.
//  - Store: ls_we=1, size=0, addr=0x103, wdata=0xAB.
//    Expect mem_we=1, mem_size=0, mem_addr=0x103 in ISSUE; ls_rvalid pulse with ls_rdata=0.
//  - halt=1 with if_req high and a fetch in flight: in-flight if_rvalid occurs, then no further if_gnt; LS still granted.
//  - MEM_LAT=3 back-to-back loads: rvalid spacing is 5 cycles; each rdata matches its own address.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, owner and size codes.
// Used by mem_port_arbiter and arb_prio_sel.
package mem_arb_pkg;

  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  // Command captured at the grant edge; the address lives beside it because its width is a parameter.
  typedef struct packed {
    owner_t          owner;
    logic            we;
    logic [1:0]      size;
    logic [DW-1:0]   wdata;
  } cmd_t;

  // Latency counter width; never zero even when no WAIT state is used.
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat > 2) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/arb_prio_sel.sv
// Combinational LS-priority grant select with an IF anti-starvation streak counter.
module arb_prio_sel
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic grant_ok,
  input  logic halt,
  input  logic if_req,
  input  logic ls_req,
  output logic if_gnt_c,
  output logic ls_gnt_c
);

  localparam int unsigned SW = $clog2(MAX_STREAK + 1);

  logic [SW-1:0] streak_q;
  logic          force_if;
  logic          if_win;

  assign force_if = (streak_q == SW'(MAX_STREAK));
  // IF wins when LS is absent or LS has starved it long enough; halt overrides both.
  assign if_win   = if_req && !halt && (!ls_req || force_if);
  assign if_gnt_c = grant_ok && if_win;
  assign ls_gnt_c = grant_ok && ls_req && !if_win;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak_q <= '0;
    end else if (!if_req || if_gnt_c) begin
      streak_q <= '0;
    end else if (ls_gnt_c && !force_if) begin
      streak_q <= streak_q + SW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store with fixed latency.
// Optional grant statistics counters are enabled by defining MEM_ARB_STATS_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned MAX_STREAK = 4,
  parameter int unsigned AW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          halt,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [1:0]    ls_size,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [DW-1:0] ls_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [1:0]    mem_size,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          idle
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]   if_grant_cnt,
  output logic [31:0]   ls_grant_cnt
`endif
);

  localparam int unsigned CW        = cnt_width(MEM_LAT);
  localparam int unsigned WAIT_LAST = (MEM_LAT > 1) ? (MEM_LAT - 2) : 0;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  cmd_t          cmd_q, cmd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          grant_ok;

  assign grant_ok = (state_q == ST_IDLE) || (state_q == ST_RESP);

  arb_prio_sel #(
    .MAX_STREAK (MAX_STREAK)
  ) u_sel (
    .clk      (clk),
    .rst      (rst),
    .grant_ok (grant_ok),
    .halt     (halt),
    .if_req   (if_req),
    .ls_req   (ls_req),
    .if_gnt_c (if_gnt),
    .ls_gnt_c (ls_gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
    end
  end

  // Next state, latency count and command capture at the grant edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    unique case (state_q)
      ST_IDLE, ST_RESP: begin
        if (if_gnt) begin
          cmd_d   = '{owner: OWN_IF, we: 1'b0, size: SZ_W, wdata: '0};
          addr_d  = if_addr;
          state_d = ST_ISSUE;
        end else if (ls_gnt) begin
          cmd_d   = '{owner: OWN_LS, we: ls_we, size: ls_size, wdata: ls_wdata};
          addr_d  = ls_addr;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = (MEM_LAT > 1) ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: begin
        if (cnt_q == CW'(WAIT_LAST)) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // RESP is the cycle mem_rdata is valid; capture it and pulse the owner's rvalid next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      if_rvalid <= (state_q == ST_RESP) && (cmd_q.owner == OWN_IF);
      ls_rvalid <= (state_q == ST_RESP) && (cmd_q.owner == OWN_LS);
      if (state_q == ST_RESP) begin
        if (cmd_q.owner == OWN_IF) begin
          if_rdata <= mem_rdata;
        end else begin
          ls_rdata <= cmd_q.we ? '0 : mem_rdata;
        end
      end
    end
  end

  assign mem_en    = (state_q == ST_ISSUE);
  assign mem_we    = cmd_q.we;
  assign mem_size  = cmd_q.size;
  assign mem_addr  = addr_q;
  assign mem_wdata = cmd_q.wdata;
  assign idle      = (state_q == ST_IDLE);

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_grant_cnt <= '0;
      ls_grant_cnt <= '0;
    end else begin
      if (if_gnt) if_grant_cnt <= if_grant_cnt + 32'd1;
      if (ls_gnt) ls_grant_cnt <= ls_grant_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3,
// a behavioural memory per instance, and response scoreboards keyed on data and arrival cycle.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int passed = 0;
  int total  = 0;

  // MEM_LAT=1 instance
  logic          rst, halt, if_req, ls_req, ls_we;
  logic [AW-1:0] if_addr, ls_addr, mem_addr;
  logic [1:0]    ls_size, mem_size;
  logic [31:0]   ls_wdata, if_rdata, ls_rdata, mem_wdata, mem_rdata;
  logic          if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_en, mem_we, idle;

  // MEM_LAT=3 instance
  logic          rst_3, halt_3, if_req_3, ls_req_3, ls_we_3;
  logic [AW-1:0] if_addr_3, ls_addr_3, mem_addr_3;
  logic [1:0]    ls_size_3, mem_size_3;
  logic [31:0]   ls_wdata_3, if_rdata_3, ls_rdata_3, mem_wdata_3, mem_rdata_3;
  logic          if_gnt_3, ls_gnt_3, if_rvalid_3, ls_rvalid_3, mem_en_3, mem_we_3, idle_3;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] if_gc, ls_gc, if_gc_3, ls_gc_3;
`endif

  mem_port_arbiter #(.MEM_LAT(1), .MAX_STREAK(4), .AW(AW)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .idle(idle)
`ifdef MEM_ARB_STATS_EN
    , .if_grant_cnt(if_gc), .ls_grant_cnt(ls_gc)
`endif
  );

  mem_port_arbiter #(.MEM_LAT(3), .MAX_STREAK(4), .AW(AW)) dut_3 (
    .clk(clk), .rst(rst_3), .halt(halt_3),
    .if_req(if_req_3), .if_addr(if_addr_3), .if_gnt(if_gnt_3), .if_rvalid(if_rvalid_3), .if_rdata(if_rdata_3),
    .ls_req(ls_req_3), .ls_we(ls_we_3), .ls_size(ls_size_3), .ls_addr(ls_addr_3), .ls_wdata(ls_wdata_3),
    .ls_gnt(ls_gnt_3), .ls_rvalid(ls_rvalid_3), .ls_rdata(ls_rdata_3),
    .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_size(mem_size_3), .mem_addr(mem_addr_3),
    .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata_3), .idle(idle_3)
`ifdef MEM_ARB_STATS_EN
    , .if_grant_cnt(if_gc_3), .ls_grant_cnt(ls_gc_3)
`endif
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h10) return 32'h0050_0093;
    return (a ^ 32'hA5A5_0000) + 32'h0101_0101;
  endfunction

  // Behavioural memories: data only in the valid cycle, garbage otherwise.
  logic        v1 = 1'b0;
  logic [31:0] a1 = '0;
  always @(posedge clk) begin
    v1 <= mem_en;
    a1 <= mem_addr;
  end
  assign mem_rdata = v1 ? memf(a1) : 32'hDEAD_BEEF;

  logic [2:0]  v3 = '0;
  logic [31:0] a3 [3];
  always @(posedge clk) begin
    v3    <= {v3[1:0], mem_en_3};
    a3[2] <= a3[1];
    a3[1] <= a3[0];
    a3[0] <= mem_addr_3;
  end
  assign mem_rdata_3 = v3[2] ? memf(a3[2]) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  typedef struct { logic [31:0] data; int cyc; } exp_t;
  exp_t q_if[$], q_ls[$], q_if_3[$], q_ls_3[$];

  // Response monitor: each rvalid pops its expected data and arrival cycle.
  always @(negedge clk) begin
    exp_t e;
    if (if_rvalid) begin
      if (q_if.size() == 0) chk("if_rvalid_unexpected", 32'(if_rvalid), 32'd0);
      else begin e = q_if.pop_front(); chk("if_rdata", if_rdata, e.data); chk("if_rvalid_cycle", 32'(cyc), 32'(e.cyc)); end
    end
    if (ls_rvalid) begin
      if (q_ls.size() == 0) chk("ls_rvalid_unexpected", 32'(ls_rvalid), 32'd0);
      else begin e = q_ls.pop_front(); chk("ls_rdata", ls_rdata, e.data); chk("ls_rvalid_cycle", 32'(cyc), 32'(e.cyc)); end
    end
    if (if_rvalid_3) begin
      if (q_if_3.size() == 0) chk("if_rvalid_3_unexpected", 32'(if_rvalid_3), 32'd0);
      else begin e = q_if_3.pop_front(); chk("if_rdata_3", if_rdata_3, e.data); chk("if_rvalid_3_cycle", 32'(cyc), 32'(e.cyc)); end
    end
    if (ls_rvalid_3) begin
      if (q_ls_3.size() == 0) chk("ls_rvalid_3_unexpected", 32'(ls_rvalid_3), 32'd0);
      else begin e = q_ls_3.pop_front(); chk("ls_rdata_3", ls_rdata_3, e.data); chk("ls_rvalid_3_cycle", 32'(cyc), 32'(e.cyc)); end
    end
  end

  task automatic drain(input string name, input int maxc);
    int n = 0;
    while ((q_if.size() + q_ls.size() + q_if_3.size() + q_ls_3.size()) != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk(name, 32'(q_if.size() + q_ls.size() + q_if_3.size() + q_ls_3.size()), 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[6];

  bit   order_ls[10];
  int   gi, ngnt, nrv, got;
  int   rv_cyc[3];
  logic [31:0] b2b_addr[3];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, SZ_B, 32'h103, 32'h0000_00AB, 32'h0};
    vecs[1] = '{1'b0, SZ_W, 32'h200, 32'h0,         memf(32'h200)};
    vecs[2] = '{1'b0, SZ_H, 32'h0FF, 32'h0,         memf(32'h0FF)};
    vecs[3] = '{1'b1, SZ_W, 32'h204, 32'hCAFE_F00D, 32'h0};
    vecs[4] = '{1'b0, SZ_B, 32'h003, 32'h0,         memf(32'h003)};
    vecs[5] = '{1'b0, SZ_W, 32'h102, 32'h0,         memf(32'h102)};
    order_ls = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    b2b_addr = '{32'h400, 32'h404, 32'h408};

    rst = 1'b0; halt = 1'b0; if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = '0; ls_addr = '0; ls_wdata = '0;
    rst_3 = 1'b0; halt_3 = 1'b0; if_req_3 = 1'b0; if_addr_3 = '0;
    ls_req_3 = 1'b0; ls_we_3 = 1'b0; ls_size_3 = '0; ls_addr_3 = '0; ls_wdata_3 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_ctl", 32'({if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_en, mem_we, mem_size}), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_data", if_rdata | ls_rdata | mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; rst_3 = 1'b1;

    // Single fetch, MEM_LAT=1
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    chk("fetch_gnt", 32'({if_gnt, ls_gnt}), 32'b10);
    q_if.push_back('{32'h0050_0093, cyc + 3});
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    chk("fetch_issue", 32'({mem_en, mem_we, mem_size}), {28'd0, 1'b1, 1'b0, SZ_W});
    chk("fetch_addr", mem_addr, 32'h10);
    @(negedge clk);
    chk("fetch_no_en_after_issue", 32'(mem_en), 32'd0);
    drain("fetch_drain", 20);
    chk("fetch_idle", 32'(idle), 32'd1);

    // LS vector table
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      ls_req = 1'b1; ls_we = vecs[i].we; ls_size = vecs[i].size;
      ls_addr = vecs[i].addr; ls_wdata = vecs[i].wdata;
      @(negedge clk);
      chk($sformatf("ls%0d_gnt", i), 32'({if_gnt, ls_gnt}), 32'b01);
      q_ls.push_back('{vecs[i].exp_rdata, cyc + 3});
      @(posedge clk); #1;
      ls_req = 1'b0;
      @(negedge clk);
      chk($sformatf("ls%0d_issue", i), 32'({mem_en, mem_we, mem_size}), 32'({1'b1, vecs[i].we, vecs[i].size}));
      chk($sformatf("ls%0d_addr", i), mem_addr, vecs[i].addr);
      chk($sformatf("ls%0d_wdata", i), mem_wdata, vecs[i].wdata);
      drain($sformatf("ls%0d_drain", i), 20);
    end
    chk("if_rdata_held", if_rdata, 32'h0050_0093);

    // Contention: both requesters held high
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h40;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = SZ_W; ls_addr = 32'h80;
    gi = 0;
    for (int n = 0; n < 60 && gi < 10; n++) begin
      @(negedge clk);
      if (if_gnt || ls_gnt) begin
        chk($sformatf("contend_gnt%0d", gi), 32'({if_gnt, ls_gnt}), order_ls[gi] ? 32'b01 : 32'b10);
        if (if_gnt) q_if.push_back('{memf(32'h40), cyc + 3});
        else        q_ls.push_back('{memf(32'h80), cyc + 3});
        gi++;
      end
    end
    chk("contend_count", 32'(gi), 32'd10);
    @(posedge clk); #1;
    if_req = 1'b0; ls_req = 1'b0;
    drain("contend_drain", 20);

    // halt with a fetch in flight and another pending
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h20;
    @(negedge clk);
    chk("halt_fetch_gnt", 32'(if_gnt), 32'd1);
    q_if.push_back('{memf(32'h20), cyc + 3});
    @(posedge clk); #1;
    halt = 1'b1;
    ngnt = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (if_gnt) ngnt++;
    end
    chk("halt_no_if_gnt", 32'(ngnt), 32'd0);
    chk("halt_inflight_done", 32'(q_if.size()), 32'd0);
    @(posedge clk); #1;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = SZ_W; ls_addr = 32'h300;
    got = 0;
    for (int n = 0; n < 5 && got == 0; n++) begin
      @(negedge clk);
      if (ls_gnt) begin
        got = 1;
        q_ls.push_back('{memf(32'h300), cyc + 3});
      end
    end
    chk("halt_ls_gnt", 32'(got), 32'd1);
    @(posedge clk); #1;
    ls_req = 1'b0;
    drain("halt_ls_drain", 20);
    @(posedge clk); #1;
    halt = 1'b0;
    @(negedge clk);
    chk("unhalt_if_gnt", 32'(if_gnt), 32'd1);
    q_if.push_back('{memf(32'h20), cyc + 3});
    @(posedge clk); #1;
    if_req = 1'b0;
    drain("unhalt_drain", 20);

    // MEM_LAT=3 back-to-back loads, each requested on the previous rvalid
    @(posedge clk); #1;
    ls_req_3 = 1'b1; ls_we_3 = 1'b0; ls_size_3 = SZ_W; ls_addr_3 = b2b_addr[0];
    @(negedge clk);
    chk("b2b_gnt0", 32'(ls_gnt_3), 32'd1);
    q_ls_3.push_back('{memf(b2b_addr[0]), cyc + 5});
    @(posedge clk); #1;
    ls_req_3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      got = 0;
      for (int n = 0; n < 20 && got == 0; n++) begin
        @(negedge clk);
        if (ls_rvalid_3) got = 1;
      end
      chk($sformatf("b2b_rvalid%0d", k), 32'(got), 32'd1);
      rv_cyc[k] = cyc;
      if (k < 2) begin
        ls_req_3 = 1'b1; ls_addr_3 = b2b_addr[k+1];
        #1;
        chk($sformatf("b2b_gnt%0d", k + 1), 32'(ls_gnt_3), 32'd1);
        q_ls_3.push_back('{memf(b2b_addr[k+1]), cyc + 5});
        @(posedge clk); #1;
        ls_req_3 = 1'b0;
      end
    end
    chk("b2b_spacing0", 32'(rv_cyc[1] - rv_cyc[0]), 32'd5);
    chk("b2b_spacing1", 32'(rv_cyc[2] - rv_cyc[1]), 32'd5);
    drain("b2b_drain", 20);

    // Reset asserted mid-WAIT drops the access
    @(posedge clk); #1;
    ls_req_3 = 1'b1; ls_addr_3 = 32'h500;
    @(negedge clk);
    chk("rstw_gnt", 32'(ls_gnt_3), 32'd1);
    @(posedge clk); #1;
    ls_req_3 = 1'b0;
    @(posedge clk); #1;
    rst_3 = 1'b0;
    @(negedge clk);
    chk("rstw_idle", 32'({idle_3, mem_en_3, ls_rvalid_3}), 32'b100);
    @(posedge clk); #3;
    rst_3 = 1'b1;
    if_req_3 = 1'b1; if_addr_3 = 32'h600;
    @(negedge clk);
    chk("rstw_if_gnt", 32'(if_gnt_3), 32'd1);
    q_if_3.push_back('{memf(32'h600), cyc + 5});
    @(posedge clk); #1;
    if_req_3 = 1'b0;
    nrv = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (ls_rvalid_3) nrv++;
    end
    chk("rstw_no_ls_rvalid", 32'(nrv), 32'd0);
    drain("rstw_drain", 20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
